// File: rtl/run_control_if.sv
// Front-panel request and processor clock-control signal bundle for run_control.
// master drives the switches and cpu_halt; slave is the sequencer.
interface run_control_if;
  logic       run_req;
  logic       halt_req;
  logic       step_req;
  logic       cpu_halt;
  logic       reset_out;
  logic       clken;
  logic [1:0] phase;
  logic       cycle_end;
  logic       running;
  logic       halted;

  modport master (
    output run_req, halt_req, step_req, cpu_halt,
    input  reset_out, clken, phase, cycle_end, running, halted
  );

  modport slave (
    input  run_req, halt_req, step_req, cpu_halt,
    output reset_out, clken, phase, cycle_end, running, halted
  );
endinterface

// File: rtl/run_control.sv
// Run/halt/step sequencer: stretches reset, then gates the processor clock on whole cycles.
// Optional single-step support is compiled in with RUN_CONTROL_STEP_EN.
module run_control #(
  parameter int unsigned RESET_CYCLES = 16
) (
  input logic         clk,
  input logic         reset,
  run_control_if.slave bus
);

  localparam int unsigned CntW = $clog2(RESET_CYCLES + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    StResetHold,
    StStopped,
    StRunning,
    StStep
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] hold_cnt_q;
  logic [1:0]      phase_q;
  logic            reset_out_q;
  logic            clken_q;
  logic            running_q;
  logic            halted_q;
  logic            halt_pend_q;
  logic            run_q;
  logic            halt_q;
  logic            run_edge;
  logic            halt_edge;
  logic            cycle_end;

  assign run_edge  = bus.run_req & ~run_q;
  assign halt_edge = bus.halt_req & ~halt_q;
  assign cycle_end = clken_q & (phase_q == 2'd3);

`ifdef RUN_CONTROL_STEP_EN
  logic step_q;
  logic step_edge;

  assign step_edge = bus.step_req & ~step_q;

  // Edge registers come out of reset high so a switch held through reset is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= 1'b1;
    end else begin
      step_q <= bus.step_req;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StResetHold;
      hold_cnt_q  <= '0;
      phase_q     <= 2'd0;
      reset_out_q <= 1'b1;
      clken_q     <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      run_q       <= 1'b1;
      halt_q      <= 1'b1;
    end else begin
      run_q  <= bus.run_req;
      halt_q <= bus.halt_req;
      case (state_q)
        StResetHold: begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          if (hold_cnt_q == HoldLast) begin
            state_q     <= StStopped;
            reset_out_q <= 1'b0;
            halted_q    <= 1'b1;
          end
        end
        StStopped: begin
          phase_q <= 2'd0;
          if (run_edge) begin
            state_q   <= StRunning;
            clken_q   <= 1'b1;
            running_q <= 1'b1;
            halted_q  <= 1'b0;
          end
`ifdef RUN_CONTROL_STEP_EN
          else if (step_edge) begin
            state_q  <= StStep;
            clken_q  <= 1'b1;
            halted_q <= 1'b0;
          end
`endif
        end
        StRunning: begin
          phase_q <= phase_q + 2'd1;
          if (cycle_end && (halt_pend_q || halt_edge || bus.cpu_halt)) begin
            state_q     <= StStopped;
            phase_q     <= 2'd0;
            clken_q     <= 1'b0;
            running_q   <= 1'b0;
            halted_q    <= 1'b1;
            halt_pend_q <= 1'b0;
          end else if (halt_edge) begin
            halt_pend_q <= 1'b1;
          end
        end
`ifdef RUN_CONTROL_STEP_EN
        StStep: begin
          phase_q <= phase_q + 2'd1;
          if (cycle_end) begin
            state_q  <= StStopped;
            phase_q  <= 2'd0;
            clken_q  <= 1'b0;
            halted_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= StStopped;
          phase_q <= 2'd0;
          clken_q <= 1'b0;
          running_q <= 1'b0;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.reset_out = reset_out_q;
  assign bus.clken     = clken_q;
  assign bus.phase     = phase_q;
  assign bus.cycle_end = cycle_end;
  assign bus.running   = running_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control: expected output vectors are queued as stimulus is applied
// and popped against the DUT outputs sampled 2 time units after each rising clock edge.
module tb_run_control;

  logic clk = 1'b0;
  logic reset = 1'b0;

  run_control_if ifc ();

  run_control #(
    .RESET_CYCLES(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   clken_cnt = 0;

  // Packed view: {0, reset_out, clken, phase[1:0], cycle_end, running, halted}
  function automatic logic [7:0] v(logic ro, logic ck, logic [1:0] ph, logic rn, logic hl);
    return {1'b0, ro, ck, ph, ck & (ph == 2'd3), rn, hl};
  endfunction

  function automatic logic [7:0] obs();
    return {1'b0, ifc.reset_out, ifc.clken, ifc.phase, ifc.cycle_end, ifc.running, ifc.halted};
  endfunction

  function automatic logic [7:0] st_stop();
    return v(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
  endfunction

  function automatic logic [7:0] st_run(logic [1:0] ph);
    return v(1'b0, 1'b1, ph, 1'b1, 1'b0);
  endfunction

  function automatic logic [7:0] st_rst();
    return v(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
  endfunction

  task automatic expect_val(string tag, logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic compare(logic [7:0] o);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed=%0h required=an expectation", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    if (ifc.clken === 1'b1) clken_cnt++;
  endtask

  task automatic cyc(string tag, logic [7:0] val);
    expect_val(tag, val);
    tick();
    compare(obs());
  endtask

  task automatic now(string tag, logic [7:0] val);
    expect_val(tag, val);
    compare(obs());
  endtask

  task automatic cnt_chk(string tag, int exp);
    expect_val(tag, 8'(exp));
    compare(8'(clken_cnt));
    clken_cnt = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.run_req  = 1'b1;
    ifc.halt_req = 1'b0;
    ifc.step_req = 1'b0;
    ifc.cpu_halt = 1'b0;
    #1 reset = 1'b1;
    #1 now("rst_async", st_rst());
    cyc("rst_hold_a", st_rst());
    cyc("rst_hold_b", st_rst());
    reset = 1'b0;
    for (int i = 0; i < 15; i++) cyc("stretch", st_rst());
    cyc("stretch_done", st_stop());
    cyc("held_run_a", st_stop());
    cyc("held_run_b", st_stop());
    cnt_chk("clken_in_reset", 0);

    // Clean start, full cycles, halt_req at phase 1.
    ifc.run_req = 1'b0;
    cyc("stop_idle", st_stop());
    ifc.run_req = 1'b1;
    cyc("start", st_run(2'd0));
    ifc.run_req = 1'b0;
    cyc("ph1", st_run(2'd1));
    cyc("ph2", st_run(2'd2));
    cyc("ph3", st_run(2'd3));
    cyc("wrap", st_run(2'd0));
    cyc("ph1b", st_run(2'd1));
    ifc.halt_req = 1'b1;
    cyc("halt_pend", st_run(2'd2));
    ifc.halt_req = 1'b0;
    cyc("halt_ph3", st_run(2'd3));
    cyc("halt_stop", st_stop());
    cnt_chk("run_len_8", 8);

    // halt_req edge exactly on the cycle_end edge.
    ifc.run_req = 1'b1;
    cyc("start2", st_run(2'd0));
    ifc.run_req = 1'b0;
    cyc("s2_ph1", st_run(2'd1));
    cyc("s2_ph2", st_run(2'd2));
    cyc("s2_ph3", st_run(2'd3));
    ifc.halt_req = 1'b1;
    cyc("halt_on_ce", st_stop());
    ifc.halt_req = 1'b0;
    cnt_chk("run_len_4a", 4);

    // cpu_halt held high.
    ifc.run_req = 1'b1;
    ifc.cpu_halt = 1'b1;
    cyc("start3", st_run(2'd0));
    ifc.run_req = 1'b0;
    cyc("s3_ph1", st_run(2'd1));
    cyc("s3_ph2", st_run(2'd2));
    cyc("s3_ph3", st_run(2'd3));
    cyc("cpu_halt_stop", st_stop());
    ifc.cpu_halt = 1'b0;
    cnt_chk("run_len_4b", 4);

    // cpu_halt only during phase 1, then run_req ignored while running.
    ifc.run_req = 1'b1;
    cyc("start4", st_run(2'd0));
    ifc.run_req = 1'b0;
    ifc.cpu_halt = 1'b1;
    cyc("s4_ph1", st_run(2'd1));
    ifc.cpu_halt = 1'b0;
    cyc("s4_ph2", st_run(2'd2));
    cyc("s4_ph3", st_run(2'd3));
    cyc("cpu_halt_low_ce", st_run(2'd0));
    ifc.run_req = 1'b1;
    cyc("run_ignored", st_run(2'd1));
    ifc.run_req = 1'b0;
    cyc("s4_ph2b", st_run(2'd2));
    cyc("s4_ph3b", st_run(2'd3));
    ifc.halt_req = 1'b1;
    ifc.run_req = 1'b1;
    cyc("halt_with_run", st_stop());
    ifc.halt_req = 1'b0;
    cnt_chk("run_len_8b", 8);
    cyc("no_restart", st_stop());
    ifc.halt_req = 1'b1;
    ifc.cpu_halt = 1'b1;
    cyc("halt_in_stopped", st_stop());
    ifc.run_req = 1'b0;
    ifc.halt_req = 1'b0;
    ifc.cpu_halt = 1'b0;
    cyc("quiet", st_stop());

`ifdef RUN_CONTROL_STEP_EN
    ifc.step_req = 1'b1;
    cyc("step0", v(1'b0, 1'b1, 2'd0, 1'b0, 1'b0));
    ifc.step_req = 1'b0;
    ifc.halt_req = 1'b1;
    cyc("step1", v(1'b0, 1'b1, 2'd1, 1'b0, 1'b0));
    ifc.halt_req = 1'b0;
    cyc("step2", v(1'b0, 1'b1, 2'd2, 1'b0, 1'b0));
    cyc("step3", v(1'b0, 1'b1, 2'd3, 1'b0, 1'b0));
    cyc("step_done", st_stop());
    cnt_chk("step_len_4", 4);
`else
    ifc.step_req = 1'b1;
    cyc("step_ignored", st_stop());
    ifc.step_req = 1'b0;
    ifc.halt_req = 1'b1;
    cyc("step_ign_b", st_stop());
    ifc.halt_req = 1'b0;
    cyc("step_ign_c", st_stop());
    cyc("step_ign_d", st_stop());
    cnt_chk("step_len_0", 0);
`endif

    // No halt left pending from the step sequence.
    ifc.run_req = 1'b1;
    cyc("start5", st_run(2'd0));
    ifc.run_req = 1'b0;
    cyc("s5_ph1", st_run(2'd1));
    cyc("s5_ph2", st_run(2'd2));
    cyc("s5_ph3", st_run(2'd3));
    cyc("no_pend", st_run(2'd0));
    ifc.halt_req = 1'b1;
    cyc("s5_ph1b", st_run(2'd1));
    ifc.halt_req = 1'b0;
    cyc("s5_ph2b", st_run(2'd2));
    cyc("s5_ph3b", st_run(2'd3));
    cyc("s5_stop", st_stop());
    cnt_chk("run_len_8c", 8);

    // Simultaneous run and step edges: run wins; then reset mid-run at phase 2.
    ifc.run_req = 1'b1;
    ifc.step_req = 1'b1;
    cyc("run_wins", st_run(2'd0));
    ifc.run_req = 1'b0;
    ifc.step_req = 1'b0;
    cyc("s6_ph1", st_run(2'd1));
    cyc("s6_ph2", st_run(2'd2));
    reset = 1'b1;
    #1 now("rst_midrun", st_rst());
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) cyc("stretch2", st_rst());
    cyc("stretch2_done", st_stop());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_control.md
# run_control

Front-panel run/halt/step sequencer for the processor clock. It stretches the power-on reset and then drives a clock-enable and a 2-bit processor phase counter that feed the clock generator. It starts, stops and single-steps the machine, and only ever stops on a processor-cycle boundary. It replaces the loose run/halt flip-flop pair with a single state machine that has defined arbitration.

## Interface

- RESET_CYCLES, default 16: number of `clk` rising edges `reset_out` stays high after `reset` deasserts; must be ≥1.

- `clk`, in, 1: raw system clock, rising-edge active.
- `reset`, in, 1: asynchronous, active-high reset.
- `run_req`, in, 1: run switch, synchronous to `clk`, debounced; acts on its rising edge.
- `halt_req`, in, 1: halt switch, synchronous, debounced; acts on its rising edge.
- `step_req`, in, 1: single-step switch, synchronous, debounced; acts on its rising edge.
- `cpu_halt`, in, 1: HALT instruction executing; level, sampled only at `cycle_end`.
- `reset_out`, out, 1: stretched system reset, active high.
- `clken`, out, 1: processor clock enable.
- `phase`, out, 2: processor phase 0..3.
- `cycle_end`, out, 1: `clken & (phase==3)`, combinational from registers.
- `running`, out, 1: state is RUNNING.
- `halted`, out, 1: state is STOPPED.

## Operation

- States are RESET_HOLD, STOPPED, RUNNING and STEP.
- Values while `reset` is high:
  - state is RESET_HOLD, hold counter is 0, `phase`=0.
  - `reset_out`=1, `clken`=0, `running`=0, `halted`=0, halt-pending flag is 0.
  - Edge-detect registers reset to 1, so a switch held through reset does not trigger an action.
- Edge detect: an edge on input X is seen at a rising edge when X=1 now and X=0 at the previous rising edge. Edge registers track their inputs in every state.
- RESET_HOLD:
  - The counter increments on each edge.
  - When it reaches RESET_CYCLES, the state goes to STOPPED and `reset_out` goes to 0 on that same edge.
  - All requests are ignored.
- STOPPED (`halted`=1, `clken`=0, `phase` held at 0):
  - A `run_req` edge moves to RUNNING.
  - A `step_req` edge moves to STEP.
  - If both edges occur together, RUNNING wins.
  - `halt_req` and `cpu_halt` are ignored.
- RUNNING (`clken`=1):
  - `phase` increments mod 4 on every edge.
  - A `halt_req` edge sets halt-pending.
  - At an edge where `cycle_end`=1, the state goes to STOPPED if any of these is true: halt-pending, a `halt_req` edge on that same edge, or `cpu_halt`=1. On that edge `phase` goes to 0 and halt-pending clears.
  - A `run_req` edge while running is ignored, including when it coincides with halt.
- STEP (`clken`=1):
  - Runs exactly one processor cycle (phases 0,1,2,3), then goes to STOPPED at `cycle_end`.
  - `run_req`, `halt_req`, `step_req` and `cpu_halt` are ignored during STEP; halt-pending is not set.
- Reset mid-operation: the machine returns to the reset values immediately, whatever the state or phase.

## Timing

- All state, counter and phase registers update on the `clk` rising edge. Outputs other than `cycle_end` are decoded from registers, so there is no input-to-output combinational path.
- Reset: `reset_out` is high for exactly RESET_CYCLES rising edges after `reset` falls. `halted` rises together with the fall of `reset_out`.
- Start latency: a request edge seen at rising edge N puts `clken`=1 and `phase`=0 in the cycle after edge N.
- Halt latency: the machine stops at the first `cycle_end` at or after the `halt_req` edge, which is at most 4 clocks later.
- A `halt_req` edge on the `cycle_end` edge itself stops on that edge.
- Halt is never sooner than a cycle boundary; a partial processor cycle is never produced.
- A run lasts a whole number of processor cycles (multiple of 4 `clken` clocks). A step is exactly 4 `clken` clocks.

## Configuration

- Macro: `RUN_CONTROL_STEP_EN`.
- Defined: STEP state and `step_req` handling are compiled in as described above.
- Undefined:
  - STEP state is removed and `step_req` is ignored (the port is kept, unused).
  - STOPPED leaves only on a `run_req` edge.
  - All other behaviour is identical.

## Test plan

- Reset and hold: assert `reset` with RESET_CYCLES=16, deassert it → `reset_out`=1 for exactly 16 edges, then `reset_out`=0 and `halted`=1 on the same edge, with `clken`=0 and `phase`=0 throughout.
- Switch held through reset: hold `run_req` high through reset and the hold period → the machine stays STOPPED. Drop `run_req`, then raise it → `clken`=1 the cycle after the edge, `phase` counts 0,1,2,3,0.
- Halt: raise `halt_req` at `phase`=1 → the machine stops at the next `cycle_end` with `phase`=0, `halted`=1, and exactly 4×k `clken` clocks in the run. Repeat with the `halt_req` edge at `phase`=3 → it stops on that edge.
- CPU halt: hold `cpu_halt`=1 while running → it stops at the next `cycle_end`. With `cpu_halt` high only during `phase`=1 and low at `phase`=3 → the machine keeps running.
- Step: with `RUN_CONTROL_STEP_EN` defined, a `step_req` edge gives exactly 4 `clken` clocks, then STOPPED. A simultaneous `run_req` and `step_req` gives RUNNING. With the macro undefined, `step_req` has no effect.
- Reset mid-run: assert `reset` at `phase`=2 while RUNNING → `clken`=0, `phase`=0 and `reset_out`=1 immediately, without waiting for a clock edge.
